// File: rtl/vc_pkg.sv
// Shared types for the victim-cache request arbiter.
package vc_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StProbeIssue = 3'd1,
    StProbeWait  = 3'd2,
    StEvictIssue = 3'd3,
    StEvictWait  = 3'd4
  } vc_arb_state_t;

  typedef enum logic {
    OP_PROBE = 1'b0,
    OP_EVICT = 1'b1
  } vc_op_t;

  // Index width for an N-entry requester vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module vc_rr_arbiter import vc_pkg::*; #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]            req,
  input  logic [idx_width(N)-1:0] ptr,
  output logic [N-1:0]            gnt_onehot,
  output logic [idx_width(N)-1:0] gnt_idx
);

  localparam int unsigned IW = idx_width(N);

  // Walk offsets from farthest to nearest so the closest request to ptr wins last.
  always_comb begin
    int k;
    k          = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % int'(N);
      if (req[k]) begin
        gnt_onehot    = '0;
        gnt_onehot[k] = 1'b1;
        gnt_idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/vc_request_arbiter.sv
// Shares one victim-cache controller between NUM_REQ L1 caches; one VC op in flight.
module vc_request_arbiter import vc_pkg::*; #(
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned LINE_BYTES   = 16,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_probe_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_probe_tag,
  output logic [NUM_REQ-1:0]              req_probe_ready,
  output logic [NUM_REQ-1:0]              req_probe_hit,
  output logic [LINE_BYTES*8-1:0]         req_probe_line,
  input  logic [NUM_REQ-1:0]              req_evict_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_evict_tag,
  input  logic [NUM_REQ*LINE_BYTES*8-1:0] req_evict_line,
  input  logic [NUM_REQ-1:0]              req_evict_dirty,
  output logic [NUM_REQ-1:0]              req_evict_ack,
  input  logic                            vc_ready,
  output logic                            vc_probe_valid,
  output logic [TAG_WIDTH-1:0]            vc_probe_tag,
  input  logic                            vc_probe_ready,
  input  logic                            vc_probe_hit,
  input  logic [LINE_BYTES*8-1:0]         vc_probe_line,
  output logic                            vc_evict_valid,
  output logic [TAG_WIDTH-1:0]            vc_evict_tag,
  output logic [LINE_BYTES*8-1:0]         vc_evict_line,
  output logic                            vc_evict_dirty,
  input  logic                            vc_evict_ack,
  output logic                            err_timeout
);

  localparam int unsigned LW = LINE_BYTES * 8;
  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  vc_arb_state_t        state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [LW-1:0]        line_q, line_d;
  logic                 dirty_q, dirty_d;
  logic [IW-1:0]        p_ptr_q, p_ptr_d, e_ptr_q, e_ptr_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   p_gnt_oh, e_gnt_oh, haz_oh, ev_oh;
  logic [IW-1:0]        p_gnt_idx, e_gnt_idx, haz_idx, ev_idx;
  logic                 haz_found, ev_dirty;
  logic [TAG_WIDTH-1:0] pr_tag, ev_tag;
  logic [LW-1:0]        ev_line;
  vc_op_t               sel_op;

  vc_rr_arbiter #(.N(NUM_REQ)) u_probe_arb (
    .req        (req_probe_valid),
    .ptr        (p_ptr_q),
    .gnt_onehot (p_gnt_oh),
    .gnt_idx    (p_gnt_idx)
  );

  vc_rr_arbiter #(.N(NUM_REQ)) u_evict_arb (
    .req        (req_evict_valid),
    .ptr        (e_ptr_q),
    .gnt_onehot (e_gnt_oh),
    .gnt_idx    (e_gnt_idx)
  );

  // Same-tag probe+evict from one requester: the evict must land first so the probe can see it.
  always_comb begin
    haz_found = 1'b0;
    haz_idx   = '0;
    haz_oh    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_probe_valid[i] && req_evict_valid[i] &&
          req_probe_tag[i*TAG_WIDTH +: TAG_WIDTH] == req_evict_tag[i*TAG_WIDTH +: TAG_WIDTH]) begin
        haz_found  = 1'b1;
        haz_idx    = IW'(i);
        haz_oh     = '0;
        haz_oh[i]  = 1'b1;
      end
    end
  end

  // Winner class selection and one-hot muxing of the winning payload.
  always_comb begin
    ev_oh    = haz_found ? haz_oh : e_gnt_oh;
    ev_idx   = haz_found ? haz_idx : e_gnt_idx;
    ev_tag   = '0;
    ev_line  = '0;
    ev_dirty = 1'b0;
    pr_tag   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ev_oh[i]) begin
        ev_tag   |= req_evict_tag[i*TAG_WIDTH +: TAG_WIDTH];
        ev_line  |= req_evict_line[i*LW +: LW];
        ev_dirty |= req_evict_dirty[i];
      end
      if (p_gnt_oh[i]) begin
        pr_tag |= req_probe_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    if (haz_found) begin
      sel_op = OP_EVICT;
    end else if ((|req_evict_valid) && starve_q == SW'(STARVE_LIMIT)) begin
      sel_op = OP_EVICT;
    end else if (|req_probe_valid) begin
      sel_op = OP_PROBE;
    end else begin
      sel_op = OP_EVICT;
    end
  end

  // FSM next state, grant latching, pointer / starvation / timeout bookkeeping.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tag_d    = tag_q;
    line_d   = line_q;
    dirty_d  = dirty_q;
    p_ptr_d  = p_ptr_q;
    e_ptr_d  = e_ptr_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    if (!(|req_evict_valid)) starve_d = '0;
    unique case (state_q)
      StIdle: begin
        if (vc_ready && ((|req_probe_valid) || (|req_evict_valid))) begin
          if (sel_op == OP_PROBE) begin
            state_d = StProbeIssue;
            owner_d = p_gnt_idx;
            tag_d   = pr_tag;
            p_ptr_d = (p_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : p_gnt_idx + 1'b1;
            if ((|req_evict_valid) && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
          end else begin
            state_d  = StEvictIssue;
            owner_d  = ev_idx;
            tag_d    = ev_tag;
            line_d   = ev_line;
            dirty_d  = ev_dirty;
            e_ptr_d  = (ev_idx == IW'(NUM_REQ - 1)) ? '0 : ev_idx + 1'b1;
            starve_d = '0;
          end
        end
      end
      StProbeIssue: begin
        state_d = StProbeWait;
        tmo_d   = '0;
      end
      StProbeWait: begin
        tmo_d = tmo_q + 1'b1;
        if (vc_probe_ready) begin
          state_d = StIdle;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StEvictIssue: begin
        state_d = StEvictWait;
        tmo_d   = '0;
      end
      StEvictWait: begin
        tmo_d = tmo_q + 1'b1;
        if (vc_evict_ack) begin
          state_d = StIdle;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      tag_q    <= '0;
      line_q   <= '0;
      dirty_q  <= 1'b0;
      p_ptr_q  <= '0;
      e_ptr_q  <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      dirty_q  <= dirty_d;
      p_ptr_q  <= p_ptr_d;
      e_ptr_q  <= e_ptr_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  // Route VC responses combinationally back to the owning requester only.
  always_comb begin
    req_probe_ready = '0;
    req_probe_hit   = '0;
    req_probe_line  = '0;
    req_evict_ack   = '0;
    if (state_q == StProbeWait) begin
      req_probe_line           = vc_probe_line;
      req_probe_ready[owner_q] = vc_probe_ready;
      req_probe_hit[owner_q]   = vc_probe_ready & vc_probe_hit;
    end
    if (state_q == StEvictWait) begin
      req_evict_ack[owner_q] = vc_evict_ack;
    end
  end

  assign vc_probe_valid = (state_q == StProbeIssue);
  assign vc_probe_tag   = tag_q;
  assign vc_evict_valid = (state_q == StEvictIssue);
  assign vc_evict_tag   = tag_q;
  assign vc_evict_line  = line_q;
  assign vc_evict_dirty = dirty_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_vc_request_arbiter.sv
// Directed bench for vc_request_arbiter with a latency-programmable VC model.
module tb_vc_request_arbiter;

  localparam int TW = 20;
  localparam int LB = 16;
  localparam int NR = 2;
  localparam int LW = LB * 8;
  localparam int OW = 3 * NR + 2 * LW + 2 * TW + 4;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_probe_valid;
  logic [NR*TW-1:0] req_probe_tag;
  logic [NR-1:0]    req_probe_ready;
  logic [NR-1:0]    req_probe_hit;
  logic [LW-1:0]    req_probe_line;
  logic [NR-1:0]    req_evict_valid;
  logic [NR*TW-1:0] req_evict_tag;
  logic [NR*LW-1:0] req_evict_line;
  logic [NR-1:0]    req_evict_dirty;
  logic [NR-1:0]    req_evict_ack;
  logic             vc_ready;
  logic             vc_probe_valid;
  logic [TW-1:0]    vc_probe_tag;
  logic             vc_probe_ready;
  logic             vc_probe_hit;
  logic [LW-1:0]    vc_probe_line;
  logic             vc_evict_valid;
  logic [TW-1:0]    vc_evict_tag;
  logic [LW-1:0]    vc_evict_line;
  logic             vc_evict_dirty;
  logic             vc_evict_ack;
  logic             err_timeout;
  logic [OW-1:0]    outs_all;

  int checks = 0;
  int errors = 0;

  // VC model knobs (written by the tests) and private countdowns.
  int            p_lat = 1;
  int            e_lat = 1;
  bit            p_drop = 1'b0;
  bit            e_drop = 1'b0;
  bit            p_hit_cfg = 1'b1;
  logic [LW-1:0] p_line_cfg = '0;
  int            p_cnt = 0;
  int            e_cnt = 0;

  vc_request_arbiter #(
    .TAG_WIDTH    (TW),
    .LINE_BYTES   (LB),
    .NUM_REQ      (NR),
    .STARVE_LIMIT (4),
    .TIMEOUT      (255)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_probe_valid (req_probe_valid),
    .req_probe_tag   (req_probe_tag),
    .req_probe_ready (req_probe_ready),
    .req_probe_hit   (req_probe_hit),
    .req_probe_line  (req_probe_line),
    .req_evict_valid (req_evict_valid),
    .req_evict_tag   (req_evict_tag),
    .req_evict_line  (req_evict_line),
    .req_evict_dirty (req_evict_dirty),
    .req_evict_ack   (req_evict_ack),
    .vc_ready        (vc_ready),
    .vc_probe_valid  (vc_probe_valid),
    .vc_probe_tag    (vc_probe_tag),
    .vc_probe_ready  (vc_probe_ready),
    .vc_probe_hit    (vc_probe_hit),
    .vc_probe_line   (vc_probe_line),
    .vc_evict_valid  (vc_evict_valid),
    .vc_evict_tag    (vc_evict_tag),
    .vc_evict_line   (vc_evict_line),
    .vc_evict_dirty  (vc_evict_dirty),
    .vc_evict_ack    (vc_evict_ack),
    .err_timeout     (err_timeout)
  );

  assign outs_all = {req_probe_ready, req_probe_hit, req_probe_line, req_evict_ack,
                     vc_probe_valid, vc_probe_tag, vc_evict_valid, vc_evict_tag,
                     vc_evict_line, vc_evict_dirty, err_timeout};

  always #5 clk = ~clk;

  // VC model: responds lat cycles after seeing an issue pulse, acting just after posedge.
  initial begin
    vc_probe_ready = 1'b0;
    vc_probe_hit   = 1'b0;
    vc_probe_line  = '0;
    vc_evict_ack   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vc_probe_ready = 1'b0;
      vc_evict_ack   = 1'b0;
      if (rst) begin
        p_cnt = 0;
        e_cnt = 0;
      end else begin
        if (p_cnt > 0) begin
          p_cnt--;
          if (p_cnt == 0) begin
            vc_probe_ready = 1'b1;
            vc_probe_hit   = p_hit_cfg;
            vc_probe_line  = p_line_cfg;
          end
        end
        if (e_cnt > 0) begin
          e_cnt--;
          if (e_cnt == 0) vc_evict_ack = 1'b1;
        end
        if (vc_probe_valid && !p_drop) p_cnt = p_lat;
        if (vc_evict_valid && !e_drop) e_cnt = e_lat;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    rst             = 1'b1;
    req_probe_valid = '0;
    req_evict_valid = '0;
    vc_ready        = 1'b1;
    p_drop          = 1'b0;
    e_drop          = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (outs_all !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", outs_all);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs_all !== '0) begin
      errors++;
      $display("FAIL idle_outputs: got %h, want 0", outs_all);
    end
  endtask

  task automatic test_single_probe();
    int t_rdy;
    int pv_cnt;
    bit side1;
    logic [LW-1:0] a5;
    a5         = {LB{8'hA5}};
    p_lat      = 2;
    p_hit_cfg  = 1'b1;
    p_line_cfg = a5;
    @(negedge clk);
    vc_ready        = 1'b0;
    req_probe_tag   = {20'h00000, 20'h12345};
    req_probe_valid = 2'b01;
    pv_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (vc_probe_valid) pv_cnt++;
    end
    checks++;
    if (pv_cnt !== 0) begin
      errors++;
      $display("FAIL stall_no_grant: got %0d issue cycles, want 0", pv_cnt);
    end
    vc_ready = 1'b1;
    t_rdy  = 0;
    side1  = 1'b0;
    pv_cnt = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (vc_probe_valid) pv_cnt++;
      if (req_probe_ready[1] || req_probe_hit[1] || req_evict_ack != 0) side1 = 1'b1;
      if (req_probe_ready != 0) begin
        t_rdy = t;
        break;
      end
    end
    checks++;
    if (t_rdy !== 3) begin
      errors++;
      $display("FAIL probe_latency: got %0d, want 3", t_rdy);
    end
    checks++;
    if (req_probe_ready !== 2'b01) begin
      errors++;
      $display("FAIL probe_ready: got %b, want 01", req_probe_ready);
    end
    checks++;
    if (req_probe_hit !== 2'b01) begin
      errors++;
      $display("FAIL probe_hit: got %b, want 01", req_probe_hit);
    end
    checks++;
    if (req_probe_line !== a5) begin
      errors++;
      $display("FAIL probe_line: got %h, want %h", req_probe_line, a5);
    end
    checks++;
    if (vc_probe_tag !== 20'h12345) begin
      errors++;
      $display("FAIL probe_tag_stable: got %h, want 12345", vc_probe_tag);
    end
    checks++;
    if (pv_cnt !== 1) begin
      errors++;
      $display("FAIL probe_issue_width: got %0d, want 1", pv_cnt);
    end
    checks++;
    if (side1 !== 1'b0) begin
      errors++;
      $display("FAIL req1_quiet: got %b, want 0", side1);
    end
    req_probe_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (req_probe_ready !== 2'b00) begin
      errors++;
      $display("FAIL probe_ready_pulse: got %b, want 00", req_probe_ready);
    end
  endtask

  task automatic test_contention();
    int order [4];
    logic [TW-1:0] tg [4];
    int exp_o [4];
    logic [TW-1:0] exp_t [4];
    int n;
    int m;
    int hits;
    exp_o = '{0, 1, 0, 1};
    exp_t = '{20'h1AAAA, 20'h2BBBB, 20'h1AAAA, 20'h2BBBB};
    for (int i = 0; i < 4; i++) begin
      order[i] = 9;
      tg[i]    = '0;
    end
    reset_dut();
    p_lat      = 1;
    p_hit_cfg  = 1'b0;
    p_line_cfg = {LB{8'h3C}};
    @(negedge clk);
    req_probe_tag   = {20'h2BBBB, 20'h1AAAA};
    req_probe_valid = 2'b11;
    n = 0;
    m = 0;
    hits = 0;
    // Both held high throughout: after req0 is served the pointer favours req1.
    for (int t = 0; t < 60 && n < 4; t++) begin
      @(negedge clk);
      if (vc_probe_valid && m < 4) begin
        tg[m] = vc_probe_tag;
        m++;
      end
      if (req_probe_ready != 0) begin
        if (req_probe_ready == 2'b01) order[n] = 0;
        else if (req_probe_ready == 2'b10) order[n] = 1;
        else order[n] = 8;
        if (req_probe_hit != 0) hits++;
        n++;
      end
    end
    req_probe_valid = 2'b00;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL contention_count: got %0d responses, want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL contention_order[%0d]: got %0d, want %0d", i, order[i], exp_o[i]);
      end
      checks++;
      if (tg[i] !== exp_t[i]) begin
        errors++;
        $display("FAIL contention_tag[%0d]: got %h, want %h", i, tg[i], exp_t[i]);
      end
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL miss_hit_flag: got %0d hits, want 0", hits);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [LW-1:0] evl;
    int np;
    int np_at_ev;
    bit seen_ev;
    logic [TW-1:0] ev_tag;
    logic [LW-1:0] ev_line;
    logic ev_dirty;
    logic [NR-1:0] ack_val;
    evl = {8{16'hBEEF}};
    reset_dut();
    p_lat     = 1;
    e_lat     = 1;
    p_hit_cfg = 1'b1;
    @(negedge clk);
    req_probe_tag   = {20'h00222, 20'h00111};
    req_evict_tag   = {20'h3C3C3, 20'h00000};
    req_evict_line  = {evl, {LW{1'b0}}};
    req_evict_dirty = 2'b10;
    req_probe_valid = 2'b11;
    req_evict_valid = 2'b10;
    np = 0;
    np_at_ev = -1;
    seen_ev  = 1'b0;
    ev_tag   = '0;
    ev_line  = '0;
    ev_dirty = 1'b0;
    ack_val  = '0;
    for (int t = 0; t < 100 && ack_val == 0; t++) begin
      @(negedge clk);
      if (vc_probe_valid) np++;
      if (vc_evict_valid && !seen_ev) begin
        seen_ev  = 1'b1;
        np_at_ev = np;
        ev_tag   = vc_evict_tag;
        ev_line  = vc_evict_line;
        ev_dirty = vc_evict_dirty;
      end
      if (req_evict_ack != 0) ack_val = req_evict_ack;
    end
    req_probe_valid = 2'b00;
    req_evict_valid = 2'b00;
    checks++;
    if (np_at_ev !== 4) begin
      errors++;
      $display("FAIL starve_probe_grants: got %0d, want 4", np_at_ev);
    end
    checks++;
    if (ev_tag !== 20'h3C3C3) begin
      errors++;
      $display("FAIL starve_evict_tag: got %h, want 3c3c3", ev_tag);
    end
    checks++;
    if (ev_line !== evl) begin
      errors++;
      $display("FAIL starve_evict_line: got %h, want %h", ev_line, evl);
    end
    checks++;
    if (ev_dirty !== 1'b1) begin
      errors++;
      $display("FAIL starve_evict_dirty: got %b, want 1", ev_dirty);
    end
    checks++;
    if (ack_val !== 2'b10) begin
      errors++;
      $display("FAIL starve_evict_ack: got %b, want 10", ack_val);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hazard();
    int ev_t;
    int ack_t;
    int pv_t;
    int pr_t;
    reset_dut();
    p_lat = 1;
    e_lat = 1;
    @(negedge clk);
    req_probe_tag   = {20'h00000, 20'h00ABC};
    req_evict_tag   = {20'h00000, 20'h00ABC};
    req_evict_line  = {{LW{1'b0}}, {LB{8'h5A}}};
    req_evict_dirty = 2'b01;
    req_probe_valid = 2'b01;
    req_evict_valid = 2'b01;
    ev_t = 0;
    ack_t = 0;
    pv_t = 0;
    pr_t = 0;
    for (int t = 1; t <= 40 && pr_t == 0; t++) begin
      @(negedge clk);
      if (vc_evict_valid && ev_t == 0) ev_t = t;
      if (vc_probe_valid && pv_t == 0) pv_t = t;
      if (req_evict_ack[0] && ack_t == 0) begin
        ack_t = t;
        req_evict_valid = 2'b00;
      end
      if (req_probe_ready[0] && pr_t == 0) begin
        pr_t = t;
        req_probe_valid = 2'b00;
      end
    end
    req_probe_valid = 2'b00;
    req_evict_valid = 2'b00;
    checks++;
    if (ev_t !== 1) begin
      errors++;
      $display("FAIL hazard_evict_issue: got cycle %0d, want 1", ev_t);
    end
    checks++;
    if (ack_t !== 2) begin
      errors++;
      $display("FAIL hazard_evict_ack: got cycle %0d, want 2", ack_t);
    end
    checks++;
    if (pv_t !== 4) begin
      errors++;
      $display("FAIL hazard_probe_issue: got cycle %0d, want 4", pv_t);
    end
    checks++;
    if (pr_t !== 5) begin
      errors++;
      $display("FAIL hazard_probe_ready: got cycle %0d, want 5", pr_t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int err_t;
    bit spurious;
    logic [NR-1:0] rdy;
    reset_dut();
    p_lat  = 1;
    p_drop = 1'b1;
    @(negedge clk);
    req_probe_tag   = {20'h00000, 20'h0F0F0};
    req_probe_valid = 2'b01;
    err_t    = 0;
    spurious = 1'b0;
    // 1 issue cycle + 255 wait cycles, flag registered on the following edge.
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (req_probe_ready != 0) spurious = 1'b1;
      if (err_timeout) begin
        err_t = t;
        break;
      end
    end
    p_drop = 1'b0;
    checks++;
    if (err_t !== 257) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d, want 257", err_t);
    end
    checks++;
    if (spurious !== 1'b0) begin
      errors++;
      $display("FAIL timeout_no_ack: got %b, want 0", spurious);
    end
    rdy = '0;
    for (int t = 0; t < 20 && rdy == 0; t++) begin
      @(negedge clk);
      rdy = req_probe_ready;
    end
    req_probe_valid = 2'b00;
    checks++;
    if (rdy !== 2'b01) begin
      errors++;
      $display("FAIL timeout_recover: got %b, want 01", rdy);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, want 1", err_timeout);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_evict();
    bit seen;
    bit quiet;
    logic [NR-1:0] ack;
    e_drop = 1'b1;
    e_lat  = 1;
    @(negedge clk);
    req_evict_tag   = {20'h7E7E7, 20'h00000};
    req_evict_line  = {{LB{8'hC3}}, {LW{1'b0}}};
    req_evict_dirty = 2'b10;
    req_evict_valid = 2'b10;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (vc_evict_valid) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (vc_evict_tag !== 20'h7E7E7) begin
      errors++;
      $display("FAIL evict_in_flight_tag: got %h, want 7e7e7", vc_evict_tag);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs_all !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, want 0", outs_all);
    end
    @(negedge clk);
    req_evict_valid = 2'b00;
    e_drop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (req_evict_ack != 0 || vc_evict_valid || vc_probe_valid || req_probe_ready != 0)
        quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_quiet: got %b, want 1", quiet);
    end
    req_evict_tag   = {20'h00000, 20'h01234};
    req_evict_valid = 2'b01;
    ack = '0;
    for (int t = 0; t < 20 && ack == 0; t++) begin
      @(negedge clk);
      ack = req_evict_ack;
    end
    req_evict_valid = 2'b00;
    checks++;
    if (ack !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_evict: got %b, want 01", ack);
    end
  endtask

  initial begin
    rst             = 1'b1;
    vc_ready        = 1'b1;
    req_probe_valid = '0;
    req_probe_tag   = '0;
    req_evict_valid = '0;
    req_evict_tag   = '0;
    req_evict_line  = '0;
    req_evict_dirty = '0;
    test_reset();
    test_single_probe();
    test_contention();
    test_starvation();
    test_hazard();
    test_timeout();
    test_reset_mid_evict();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
